// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder tick generator.
package encoder_pkg;

   // The encoding of each quadrature state is its {A,B} pair.
   typedef enum logic [1:0] {
      Q00 = 2'b00,
      Q10 = 2'b10,
      Q11 = 2'b11,
      Q01 = 2'b01
   } quad_state_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } gen_state_t;

   localparam int DEFAULT_TICKS_PER_MICROSECOND = 50;

   // Forward walks 00->10->11->01->00, reverse walks the same ring backwards.
   function automatic quad_state_t quad_next(input quad_state_t q, input logic dir);
      quad_state_t n;
      case (q)
         Q00:     n = dir ? Q10 : Q01;
         Q10:     n = dir ? Q11 : Q00;
         Q11:     n = dir ? Q01 : Q10;
         Q01:     n = dir ? Q00 : Q11;
         default: n = Q00;
      endcase
      return n;
   endfunction

   function automatic logic [1:0] quad_to_ab(input quad_state_t q);
      return q;
   endfunction

endpackage

// File: rtl/us_strobe_gen.sv
// Microsecond prescaler: counts 0..T-1 while running, pulses us_strobe on the wrap.
module us_strobe_gen
   import encoder_pkg::*;
#(
   parameter int TICKS_PER_MICROSECOND = DEFAULT_TICKS_PER_MICROSECOND
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic us_strobe
);

   localparam logic [7:0] WRAP = 8'(TICKS_PER_MICROSECOND - 1);

   logic [7:0] prescaler;

   // Prescaler with synchronous clear taking priority over counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
      end else if (clear) begin
         prescaler <= '0;
      end else if (run) begin
         if (prescaler == WRAP) prescaler <= '0;
         else                   prescaler <= prescaler + 8'd1;
      end
   end

   assign us_strobe = run && (prescaler == WRAP);

endmodule

// File: rtl/encoder_tick_generator.sv
// Quadrature A/B generator: one Gray-coded step every period_us microseconds.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | outputs hold, waiting for enable with a non-zero period
//  RUN   | timing an interval; step on the last microsecond's wrap
module encoder_tick_generator
   import encoder_pkg::*;
#(
   parameter int TICKS_PER_MICROSECOND = DEFAULT_TICKS_PER_MICROSECOND
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        direction,
   input  logic [31:0] period_us,
   output logic        enc_a,
   output logic        enc_b,
   output logic        state_change,
   output logic [31:0] position,
   output logic        busy
);

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_RUN  = RUN;

   logic [0:0]  state;
   quad_state_t quad;
   logic [31:0] us_count;
   logic [31:0] active_period;
   logic        us_strobe;
   logic        step;
   logic        pre_clear;
   logic        pre_run;

   // Nested counters: the P*T product is never formed, so any 32-bit period is legal.
   assign step      = (state == ST_RUN) && enable && us_strobe &&
                      (us_count == active_period - 32'd1);
   assign pre_run   = (state == ST_RUN);
   assign pre_clear = (state == ST_IDLE) || !enable || step;

   us_strobe_gen #(
      .TICKS_PER_MICROSECOND(TICKS_PER_MICROSECOND)
   ) u_us_strobe (
      .clk       (clk),
      .reset     (reset),
      .clear     (pre_clear),
      .run       (pre_run),
      .us_strobe (us_strobe)
   );

   // FSM, interval counter and quadrature/position registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         busy          <= 1'b0;
         quad          <= Q00;
         position      <= '0;
         state_change  <= 1'b0;
         us_count      <= '0;
         active_period <= '0;
      end else begin
         state_change <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable && (period_us != '0)) begin
                  active_period <= period_us;
                  us_count      <= '0;
                  state         <= ST_RUN;
                  busy          <= 1'b1;
               end
            end
            ST_RUN: begin
               // Dropping enable wins over a step due on the same edge.
               if (!enable) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  us_count <= '0;
               end else if (step) begin
                  quad          <= quad_next(quad, direction);
                  position      <= direction ? position + 32'd1 : position - 32'd1;
                  state_change  <= 1'b1;
                  us_count      <= '0;
                  active_period <= period_us;
                  if (period_us == '0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else if (us_strobe) begin
                  us_count <= us_count + 32'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign {enc_a, enc_b} = quad_to_ab(quad);

endmodule

// File: tb/tb_encoder_tick_generator.sv
// Bench for encoder_tick_generator: directed table, corner sequences, random vs model.
module tb_encoder_tick_generator;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        en4 = 1'b0, dir4 = 1'b1;
   logic [31:0] per4 = '0;
   logic        a4, b4, sc4, busy4;
   logic [31:0] pos4;

   logic        en1 = 1'b0, dir1 = 1'b1;
   logic [31:0] per1 = '0;
   logic        a1, b1, sc1, busy1;
   logic [31:0] pos1;

   always #5 clk = ~clk;

   encoder_tick_generator #(.TICKS_PER_MICROSECOND(T)) dut4 (
      .clk(clk), .reset(reset), .enable(en4), .direction(dir4), .period_us(per4),
      .enc_a(a4), .enc_b(b4), .state_change(sc4), .position(pos4), .busy(busy4)
   );

   encoder_tick_generator #(.TICKS_PER_MICROSECOND(1)) dut1 (
      .clk(clk), .reset(reset), .enable(en1), .direction(dir1), .period_us(per1),
      .enc_a(a1), .enc_b(b1), .state_change(sc1), .position(pos1), .busy(busy1)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sc(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!sc4 && n < 200);
   endtask

   typedef struct {
      logic        dir;
      logic [31:0] per;
      int          gap;
      logic [1:0]  ab;
      logic [31:0] pos;
   } vec_t;

   vec_t vecs[8];

   // AB pattern as a function of position mod 4 (position starts at 0 with AB=00).
   logic [1:0] ab_tab[4];

   // Reference model: a single countdown of remaining clocks to the next step.
   logic        m_run;
   longint      m_left;
   logic [31:0] m_pos;
   logic        m_sc;

   task automatic model_reset();
      m_run = 1'b0; m_left = 0; m_pos = '0; m_sc = 1'b0;
   endtask

   task automatic model_edge(input logic en, input logic dir, input logic [31:0] per);
      m_sc = 1'b0;
      if (!m_run) begin
         if (en && per != 0) begin
            m_run  = 1'b1;
            m_left = longint'(per) * T;
         end
      end else if (!en) begin
         m_run = 1'b0;
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_sc  = 1'b1;
            m_pos = dir ? m_pos + 32'd1 : m_pos - 32'd1;
            if (per == 0) m_run = 1'b0;
            else          m_left = longint'(per) * T;
         end
      end
   endtask

   initial begin
      int n;
      logic [1:0] prev_ab;
      logic any_bad;

      ab_tab[0] = 2'b00; ab_tab[1] = 2'b10; ab_tab[2] = 2'b11; ab_tab[3] = 2'b01;

      vecs[0] = '{1'b1, 32'd3, 12, 2'b10, 32'd1};
      vecs[1] = '{1'b1, 32'd3, 12, 2'b11, 32'd2};
      vecs[2] = '{1'b1, 32'd3, 12, 2'b01, 32'd3};
      vecs[3] = '{1'b1, 32'd3, 12, 2'b00, 32'd4};
      vecs[4] = '{1'b1, 32'd3, 12, 2'b10, 32'd5};
      vecs[5] = '{1'b1, 32'd3, 12, 2'b11, 32'd6};
      vecs[6] = '{1'b0, 32'd3, 12, 2'b10, 32'd5};
      vecs[7] = '{1'b0, 32'd3, 12, 2'b00, 32'd4};

      repeat (2) cyc();
      chk("reset_outputs", {a4, b4, sc4, busy4, pos4}, 36'h0);
      reset = 1'b0;

      // Reset asserted mid-run clears everything immediately.
      en4 = 1'b1; dir4 = 1'b1; per4 = 32'd3;
      repeat (20) cyc();
      #2 reset = 1'b1;
      #1;
      chk("async_reset", {a4, b4, sc4, busy4, pos4}, 36'h0);
      cyc();
      reset = 1'b0;
      cyc();
      chk("start_busy", {sc4, busy4}, 2'b01);

      // Table of consecutive steps, including a mid-run direction reversal.
      prev_ab = 2'b00;
      for (int i = 0; i < 8; i++) begin
         dir4 = vecs[i].dir;
         per4 = vecs[i].per;
         wait_sc(n);
         chk($sformatf("gap[%0d]", i), n, vecs[i].gap);
         chk($sformatf("ab[%0d]", i), {a4, b4}, vecs[i].ab);
         chk($sformatf("pos[%0d]", i), pos4, vecs[i].pos);
         chk($sformatf("busy[%0d]", i), busy4, 1'b1);
         chk($sformatf("onebit[%0d]", i), $countones(prev_ab ^ {a4, b4}), 1);
         prev_ab = {a4, b4};
      end

      // Period change mid-interval applies only after the current step.
      dir4 = 1'b1;
      repeat (5) cyc();
      per4 = 32'd5;
      wait_sc(n);
      chk("per_chg_cur", n, 7);
      chk("per_chg_pos", pos4, 32'd5);
      wait_sc(n);
      chk("per_chg_next", n, 20);
      chk("per_chg_ab", {a4, b4}, 2'b11);

      // Enable dropped on the very edge a step is due: no step.
      repeat (19) cyc();
      en4 = 1'b0;
      cyc();
      chk("en_wins", {sc4, busy4, a4, b4, pos4}, {4'b0011, 32'd6});

      // Enable dropped 5 clocks before a due step, then reasserted.
      en4 = 1'b1; per4 = 32'd3;
      cyc();
      chk("reen_busy", busy4, 1'b1);
      repeat (7) cyc();
      en4 = 1'b0;
      cyc();
      chk("drop_hold", {sc4, busy4, a4, b4, pos4}, {4'b0011, 32'd6});
      any_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (sc4 || busy4) any_bad = 1'b1;
      end
      chk("idle_quiet", any_bad, 1'b0);
      en4 = 1'b1;
      cyc();
      wait_sc(n);
      chk("reen_gap", n, 12);
      chk("reen_pos", {a4, b4, pos4}, {2'b01, 32'd7});

      // Period 0 sampled at the step edge: the step happens, then IDLE.
      per4 = 32'd0;
      wait_sc(n);
      chk("p0_step", {n[7:0], a4, b4, busy4, pos4}, {8'd12, 2'b00, 1'b0, 32'd8});
      any_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (busy4 || sc4) any_bad = 1'b1;
      end
      chk("p0_stays_idle", any_bad, 1'b0);

      // T=1, P=1 reverse: a step every clock with position wrapping below zero.
      en1 = 1'b1; dir1 = 1'b0; per1 = 32'd1;
      cyc();
      chk("t1_start", {sc1, busy1}, 2'b01);
      cyc();
      chk("t1_s1", {sc1, a1, b1, pos1}, {3'b101, 32'hFFFF_FFFF});
      cyc();
      chk("t1_s2", {sc1, a1, b1, pos1}, {3'b111, 32'hFFFF_FFFE});
      dir1 = 1'b1;
      cyc();
      chk("t1_f1", {sc1, a1, b1, pos1}, {3'b101, 32'hFFFF_FFFF});
      cyc();
      chk("t1_f2", {sc1, a1, b1, pos1}, {3'b100, 32'h0});
      cyc();
      chk("t1_f3", {sc1, a1, b1, pos1}, {3'b110, 32'h1});
      en1 = 1'b0;

      // Randomized run compared cycle by cycle against the model.
      en4 = 1'b0; per4 = 32'd2; dir4 = 1'b1;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 1500; i++) begin
         en4 = ($urandom_range(0, 31) != 0);
         if ($urandom_range(0, 15) == 0) dir4 = ~dir4;
         if ($urandom_range(0, 19) == 0) per4 = 32'($urandom_range(0, 3));
         @(posedge clk);
         model_edge(en4, dir4, per4);
         #1;
         chk($sformatf("rand[%0d]", i), {a4, b4, sc4, busy4, pos4},
             {ab_tab[m_pos[1:0]], m_sc, m_run, m_pos});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
